// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU execute controller: FSM states, operand classes,
// funcode class masks and immediate opcodes.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_RR   = 2'd0,
    CLS_RS   = 2'd1,
    CLS_IMM  = 2'd2,
    CLS_NONE = 2'd3
  } op_class_t;

  // Bit f set means funcode f belongs to the class.
  localparam logic [15:0] RR_FUNC_MASK = 16'h2CDD;  // 0,2,3,4,6,7,10,11,13
  localparam logic [15:0] RS_FUNC_MASK = 16'h1300;  // 8,9,12

  localparam logic [5:0] OPC_IMM_A = 6'h01;
  localparam logic [5:0] OPC_IMM_B = 6'h05;

  // RR wins over RS, and both win over the immediate opcodes.
  function automatic op_class_t classify(input logic [5:0] opcode);
    op_class_t cls;
    cls = CLS_NONE;
    if (RR_FUNC_MASK[opcode[3:0]])
      cls = CLS_RR;
    else if (RS_FUNC_MASK[opcode[3:0]])
      cls = CLS_RS;
    else if (opcode == OPC_IMM_A || opcode == OPC_IMM_B)
      cls = CLS_IMM;
    return cls;
  endfunction

endpackage

// File: rtl/alu_operand_sel.sv
// Combinational instruction classifier and ALU operand former.
module alu_operand_sel
  import alu_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output op_class_t   op_class,
  output logic [31:0] inp1,
  output logic [31:0] inp2
);

  always_comb begin
    op_class = classify(opcode);
    inp1     = '0;
    inp2     = '0;
    case (op_class)
      CLS_RR: begin
        inp1 = rs_data;
        inp2 = rt_data;
      end
      CLS_RS: begin
        inp1 = rs_data;
        inp2 = {27'b0, shamt};
      end
      CLS_IMM: begin
        inp1 = rs_data;
        inp2 = {{16{imm[15]}}, imm};
      end
      default: begin
        inp1 = '0;
        inp2 = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// ALU execute controller: accepts decoded instructions, launches the ALU and
// holds the result for write-back. Optional WAIT abort under ALU_TIMEOUT_EN.
//
// state | meaning
// IDLE  | ready for an instruction; non-ALU instructions pulse no_alu here
// EXEC  | operands registered, alu_start high for this single cycle
// WAIT  | waiting for alu_done (abort after TIMEOUT_CYC when enabled)
// WB    | wb_valid held with captured result until wb_ready
module alu_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic [31:0] alu_inp1,
  output logic [31:0] alu_inp2,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  input  logic        wb_ready,
  output logic        no_alu,
  output logic        timeout
);

  state_t      state;
  op_class_t   sel_class;
  logic [31:0] sel_inp1;
  logic [31:0] sel_inp2;
  logic        wait_expired;

  alu_operand_sel u_operand_sel (
    .opcode   (opcode),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .shamt    (shamt),
    .imm      (imm),
    .op_class (sel_class),
    .inp1     (sel_inp1),
    .inp2     (sel_inp2)
  );

  // Gated by rst_n so the handshake is low for the whole reset window.
  assign instr_ready = rst_n & (state == ST_IDLE);

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] wait_cnt;
  assign wait_expired = (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic unused_cfg;
  assign unused_cfg   = ^TIMEOUT_CYC;
  assign wait_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      alu_inp1  <= '0;
      alu_inp2  <= '0;
      alu_start <= 1'b0;
      wb_valid  <= 1'b0;
      wb_data   <= '0;
      no_alu    <= 1'b0;
      timeout   <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      alu_start <= 1'b0;
      no_alu    <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            if (sel_class == CLS_NONE) begin
              no_alu <= 1'b1;
            end else begin
              alu_inp1  <= sel_inp1;
              alu_inp2  <= sel_inp2;
              alu_start <= 1'b1;
              state     <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          state <= ST_WAIT;
`ifdef ALU_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_WAIT: begin
          if (alu_done) begin
            wb_data  <= alu_result;
            wb_valid <= 1'b1;
            state    <= ST_WB;
          end else if (wait_expired) begin
            timeout <= 1'b1;
            state   <= ST_IDLE;
          end
`ifdef ALU_TIMEOUT_EN
          if (!alu_done && !wait_expired)
            wait_cnt <= wait_cnt + 1'b1;
`endif
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed, table-driven bench for alu_exec_ctrl; the WAIT sequence checks the
// abort path when ALU_TIMEOUT_EN is defined and the endless wait otherwise.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [5:0]  opcode = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [4:0]  shamt = '0;
  logic [15:0] imm = '0;
  logic [31:0] alu_inp1;
  logic [31:0] alu_inp2;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [31:0] alu_result = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        wb_ready = 1'b0;
  logic        no_alu;
  logic        timeout;

  int total = 0;
  int bad = 0;

  alu_exec_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .shamt       (shamt),
    .imm         (imm),
    .alu_inp1    (alu_inp1),
    .alu_inp2    (alu_inp2),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .no_alu      (no_alu),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  opcode;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  shamt;
    logic [15:0] imm;
    bit          is_alu;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sh, input logic [15:0] im);
    opcode  = op;
    rs_data = rs;
    rt_data = rt;
    shamt   = sh;
    imm     = im;
  endtask

  initial begin
    vecs[0]  = '{6'h00, 32'd5,         32'd7,         5'd0,  16'h0000, 1'b1, 32'd5,         32'd7,         32'd12};
    vecs[1]  = '{6'h01, 32'd10,        32'h123,       5'd3,  16'hFFFE, 1'b1, 32'd10,        32'hFFFF_FFFE, 32'd8};
    vecs[2]  = '{6'h05, 32'd3,         32'd0,         5'd0,  16'h7FFF, 1'b1, 32'd3,         32'h0000_7FFF, 32'h8002};
    vecs[3]  = '{6'h08, 32'h100,       32'd9,         5'd31, 16'h1234, 1'b1, 32'h100,       32'h0000_001F, 32'h8000_0000};
    vecs[4]  = '{6'h0F, 32'hFFFF,      32'hEEEE,      5'd5,  16'h0001, 1'b0, 32'h100,       32'h0000_001F, 32'd0};
    vecs[5]  = '{6'h2D, 32'hAAAA_AAAA, 32'h5555_5555, 5'd1,  16'h8000, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF};
    vecs[6]  = '{6'h11, 32'd1,         32'd2,         5'd0,  16'h0005, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 32'd0};
    vecs[7]  = '{6'h0C, 32'd7,         32'hFF,        5'd0,  16'hFFFF, 1'b1, 32'd7,         32'd0,         32'd7};
    vecs[8]  = '{6'h21, 32'd4,         32'd4,         5'd4,  16'h0004, 1'b0, 32'd7,         32'd0,         32'd0};
    vecs[9]  = '{6'h1A, 32'h10,        32'h20,        5'd2,  16'h0002, 1'b1, 32'h10,        32'h20,        32'h30};
    vecs[10] = '{6'h39, 32'hC0DE,      32'h77,        5'd4,  16'h0003, 1'b1, 32'hC0DE,      32'd4,         32'hC0E2};

    // Reset values while rst_n is held low.
    #1;
    chk("rst_ready", {31'b0, instr_ready}, 32'd0);
    chk("rst_inp1", alu_inp1, 32'd0);
    chk("rst_inp2", alu_inp2, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_start", {31'b0, alu_start}, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {31'b0, instr_ready}, 32'd1);
    step();

    // Table-driven single instructions with minimum-latency completion.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].opcode, vecs[i].rs, vecs[i].rt, vecs[i].shamt, vecs[i].imm);
      instr_valid = 1'b1;
      chk("vec_ready", {31'b0, instr_ready}, 32'd1);
      step();
      instr_valid = 1'b0;
      chk("vec_inp1", alu_inp1, vecs[i].e1);
      chk("vec_inp2", alu_inp2, vecs[i].e2);
      if (vecs[i].is_alu) begin
        chk("vec_start", {31'b0, alu_start}, 32'd1);
        chk("vec_no_alu", {31'b0, no_alu}, 32'd0);
        step();
        chk("vec_start_gone", {31'b0, alu_start}, 32'd0);
        chk("vec_wb_early", {31'b0, wb_valid}, 32'd0);
        alu_done   = 1'b1;
        alu_result = vecs[i].res;
        step();
        alu_done = 1'b0;
        chk("vec_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("vec_wb_data", wb_data, vecs[i].res);
        chk("vec_ready_wb", {31'b0, instr_ready}, 32'd0);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("vec_wb_clear", {31'b0, wb_valid}, 32'd0);
        chk("vec_ready_back", {31'b0, instr_ready}, 32'd1);
      end else begin
        chk("vec_no_alu", {31'b0, no_alu}, 32'd1);
        chk("vec_start_none", {31'b0, alu_start}, 32'd0);
        chk("vec_ready_none", {31'b0, instr_ready}, 32'd1);
        step();
        chk("vec_no_alu_pulse", {31'b0, no_alu}, 32'd0);
        chk("vec_start_none2", {31'b0, alu_start}, 32'd0);
      end
    end

    // Back-pressure: result held while wb_ready low, new instruction waits.
    drive(6'h02, 32'd1, 32'd2, 5'd0, 16'h0);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    alu_done   = 1'b1;
    alu_result = 32'h33;
    step();
    alu_done = 1'b0;
    drive(6'h00, 32'h44, 32'h55, 5'd0, 16'h0);
    instr_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      alu_done   = (c == 2);
      alu_result = 32'h99;
      chk("bp_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("bp_wb_data", wb_data, 32'h33);
      chk("bp_ready", {31'b0, instr_ready}, 32'd0);
      chk("bp_start", {31'b0, alu_start}, 32'd0);
      step();
    end
    alu_done = 1'b0;
    chk("bp_wb_data_end", wb_data, 32'h33);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("bp_idle_ready", {31'b0, instr_ready}, 32'd1);
    chk("bp_no_bypass", {31'b0, alu_start}, 32'd0);
    chk("bp_inp1_hold", alu_inp1, 32'd1);
    step();
    instr_valid = 1'b0;
    chk("bp_next_start", {31'b0, alu_start}, 32'd1);
    chk("bp_next_inp1", alu_inp1, 32'h44);
    chk("bp_next_inp2", alu_inp2, 32'h55);
    step();
    alu_done   = 1'b1;
    alu_result = 32'h77;
    step();
    alu_done = 1'b0;
    chk("bp_next_wb", wb_data, 32'h77);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // alu_done outside WAIT must not be captured.
    drive(6'h03, 32'd2, 32'd3, 5'd0, 16'h0);
    alu_done    = 1'b1;
    alu_result  = 32'hDEAD;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("sp_start", {31'b0, alu_start}, 32'd1);
    step();
    alu_done = 1'b0;
    chk("sp_wb_exec", {31'b0, wb_valid}, 32'd0);
    step();
    chk("sp_wb_wait", {31'b0, wb_valid}, 32'd0);
    alu_done   = 1'b1;
    alu_result = 32'h5;
    step();
    alu_done = 1'b0;
    chk("sp_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk("sp_wb_data", wb_data, 32'h5);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // Stalled ALU: abort after 16 WAIT cycles, or wait indefinitely.
    drive(6'h04, 32'd9, 32'd9, 5'd0, 16'h0);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
`ifdef ALU_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      step();
      chk("to_early", {31'b0, timeout}, 32'd0);
      chk("to_busy", {31'b0, instr_ready}, 32'd0);
    end
    step();
    chk("to_pulse", {31'b0, timeout}, 32'd1);
    chk("to_idle", {31'b0, instr_ready}, 32'd1);
    chk("to_no_wb", {31'b0, wb_valid}, 32'd0);
    chk("to_wb_data", wb_data, 32'h5);
    step();
    chk("to_pulse_end", {31'b0, timeout}, 32'd0);
`else
    for (int c = 0; c < 20; c++) begin
      step();
      chk("nt_timeout", {31'b0, timeout}, 32'd0);
      chk("nt_busy", {31'b0, instr_ready}, 32'd0);
      chk("nt_no_wb", {31'b0, wb_valid}, 32'd0);
    end
    alu_done   = 1'b1;
    alu_result = 32'h1234;
    step();
    alu_done = 1'b0;
    chk("nt_wb_data", wb_data, 32'h1234);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
`endif

    // Asynchronous reset in the middle of WAIT.
    drive(6'h06, 32'h11, 32'h22, 5'd0, 16'h0);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ready", {31'b0, instr_ready}, 32'd0);
    chk("ar_inp1", alu_inp1, 32'd0);
    chk("ar_inp2", alu_inp2, 32'd0);
    chk("ar_wb_data", wb_data, 32'd0);
    chk("ar_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("ar_start", {31'b0, alu_start}, 32'd0);
    chk("ar_no_alu", {31'b0, no_alu}, 32'd0);
    chk("ar_timeout", {31'b0, timeout}, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("ar_ready_after", {31'b0, instr_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum WAIT-state cycles before abort (requires ALU_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 instr_valid  in  1  decoded instruction present.
REQ-005 instr_ready  out  1  block can accept an instruction; high only in IDLE.
REQ-006 opcode  in  6  instruction opcode; [3:0] is funcode.
REQ-007 rs_data, rt_data  in  32 each  register-file read data.
REQ-008 shamt  in  5  shift amount field.
REQ-009 imm  in  16  immediate field.
REQ-010 alu_inp1, alu_inp2  out  32 each  registered ALU operands.
REQ-011 alu_start  out  1  one-cycle ALU launch pulse.
REQ-012 alu_done  in  1  ALU result valid.
REQ-013 alu_result  in  32  ALU result.
REQ-014 wb_valid  out  1  write-back data valid.
REQ-015 wb_data  out  32  captured result.
REQ-016 wb_ready  in  1  write-back consumer accepts.
REQ-017 no_alu  out  1  one-cycle pulse: accepted instruction needs no ALU.
REQ-018 timeout  out  1  one-cycle pulse: ALU abort (ALU_TIMEOUT_EN only; else tied 0).

Function
REQ-019 Classification SHALL use this priority: funcode in {0,2,3,4,6,7,10,11,13} -> RR; else funcode in {8,9,12} -> RS; else opcode in {1,5} -> IMM; else NONE.
REQ-020 Operands: RR -> inp1=rs_data, inp2=rt_data; RS -> inp1=rs_data, inp2={27'b0,shamt}; IMM -> inp1=rs_data, inp2=sign-extended imm; NONE -> both 0.
REQ-021 FSM states SHALL be IDLE, EXEC, WAIT, WB.
REQ-022 IDLE: on instr_valid, class RR/RS/IMM -> latch operands into alu_inp1/alu_inp2, go EXEC; class NONE -> pulse no_alu next cycle, stay IDLE, operands unchanged.
REQ-023 EXEC: alu_start=1 for exactly this one cycle; next state WAIT unconditionally.
REQ-024 WAIT: alu_done sampled only here; on alu_done capture alu_result into wb_data, go WB.
REQ-025 alu_done outside WAIT SHALL be ignored.
REQ-026 WB: wb_valid=1 held, wb_data stable, until wb_ready; on wb_ready go IDLE.
REQ-027 Minimum accept-to-wb_valid latency 3 cycles (accept N, start N+1, done N+2, wb_valid N+3).
REQ-028 alu_inp1/alu_inp2 SHALL hold stable from EXEC until next accepted ALU instruction.
REQ-029 New instruction accepted earliest the cycle after wb_ready handshake (no bypass).

Reset
REQ-030 rst_n low SHALL immediately force IDLE and clear alu_inp1, alu_inp2, wb_data, alu_start, wb_valid, no_alu, timeout, timeout counter, regardless of state.
REQ-031 instr_ready SHALL be 0 while rst_n low and 1 in the first cycle after release.

Configuration
REQ-032 Macro ALU_TIMEOUT_EN defined: counter counts WAIT cycles; reaching TIMEOUT_CYC without alu_done -> pulse timeout, wb_data unchanged, go IDLE; counter clears on entering WAIT.
REQ-033 ALU_TIMEOUT_EN undefined: no counter; WAIT persists until alu_done; timeout tied 0.

Structure
REQ-034 Package alu_ctrl_pkg SHALL hold state encoding, operand-class encoding (RR, RS, IMM, NONE), funcode class constants, immediate opcode constants.
REQ-035 Combinational classifier/operand former SHALL be sub-module alu_operand_sel; FSM, registers, counter in alu_exec_ctrl.

Verification
REQ-036 RR: opcode 6'h00, rs=5, rt=7; alu_done at N+2 with result 12 -> alu_inp1=5, inp2=7, alu_start at N+1, wb_valid at N+3, wb_data=12.
REQ-037 IMM negative: opcode 6'h01, imm 16'hFFFE, rs=10 -> alu_inp2=32'hFFFF_FFFE; opcode 6'h05, imm 16'h7FFF -> 32'h0000_7FFF.
REQ-038 RS: opcode 6'h08, shamt 31, rt=9 -> alu_inp2=32'h0000_001F, rt ignored.
REQ-039 NONE: opcode 6'h0F -> no_alu pulse 1 cycle, no alu_start, instr_ready stays 1.
REQ-040 Back-pressure: wb_ready low 5 cycles in WB, alu_done pulsed again -> wb_valid held, wb_data unchanged, no new accept.
REQ-041 Timeout (ALU_TIMEOUT_EN, TIMEOUT_CYC=16): no alu_done -> timeout pulse after 16 WAIT cycles, IDLE next; rst_n low mid-WAIT -> all outputs 0 asynchronously.
